dma_chan_fifo: RTL

Multi-channel buffering FIFO for the DMA datapath. It holds NUM_CH independent logical queues in one statically partitioned storage array, each queue DEPTH entries deep. One write port and one read port are each steered by a channel id. Every channel exposes full, empty, occupancy and almost-full/almost-empty status, so the DMA scheduler can arbitrate channels without keeping shadow counters.

---
 rtl/dma_chan_fifo.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/dma_chan_fifo.sv
// dma_chan_fifo: NUM_CH independent FIFOs sharing one statically partitioned
// storage array. Each channel owns DEPTH entries addressed as {ch, ptr_low}.
// Optional sticky overflow/underflow flags are built when the macro
// DMA_CHAN_FIFO_ERR_FLAGS_EN is defined.
//
// Handshake: a write is accepted on a rising edge where wr_valid_i and
// wr_ready_o are both high (and the target channel is not being cleared); a
// pop is accepted where rd_req_i is high and the selected channel is non-empty
// (and not being cleared). Each accepted pop produces exactly one cycle of
// rd_valid_o on the following cycle; rd_data_o/rd_ch_o hold otherwise.
module dma_chan_fifo #(
    parameter int NUM_CH    = 4,
    parameter int DEPTH     = 64,
    parameter int WIDTH     = 128,
    parameter int AF_THRESH = DEPTH - 4,
    parameter int AE_THRESH = 4,
    localparam int CHW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CW       = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NUM_CH-1:0]    clear_i,
    input  logic                 wr_valid_i,
    input  logic [CHW-1:0]       wr_ch_i,
    input  logic [WIDTH-1:0]     wr_data_i,
    output logic                 wr_ready_o,
    input  logic                 rd_req_i,
    input  logic [CHW-1:0]       rd_ch_i,
    output logic                 rd_valid_o,
    output logic [CHW-1:0]       rd_ch_o,
    output logic [WIDTH-1:0]     rd_data_o,
    output logic [NUM_CH-1:0]    full_o,
    output logic [NUM_CH-1:0]    empty_o,
    output logic [NUM_CH-1:0]    almost_full_o,
    output logic [NUM_CH-1:0]    almost_empty_o,
    output logic [NUM_CH*CW-1:0] count_o
`ifdef DMA_CHAN_FIFO_ERR_FLAGS_EN
    ,
    output logic [NUM_CH-1:0]    err_ovf_o,
    output logic [NUM_CH-1:0]    err_udf_o
`endif
);

    localparam int AW = CHW + CW - 1;

    logic [CW-1:0]    wr_ptr [NUM_CH];
    logic [CW-1:0]    rd_ptr [NUM_CH];
    logic [CW-1:0]    cnt    [NUM_CH];

    // Storage is sized to the full channel-id space so every {ch, low}
    // address is in range even when NUM_CH is not a power of two.
    logic [WIDTH-1:0] mem [(2**CHW)*DEPTH];

    logic             wr_full_sel;
    logic             wr_clr_sel;
    logic [CW-2:0]    wr_low;
    logic             rd_empty_sel;
    logic             rd_clr_sel;
    logic [CW-2:0]    rd_low;
    logic             wr_acc;
    logic             rd_acc;
    logic [AW-1:0]    waddr;
    logic [AW-1:0]    raddr;

    // Per-channel status, purely a function of the registered pointers.
    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_status
            assign cnt[g]            = wr_ptr[g] - rd_ptr[g];
            assign empty_o[g]        = (wr_ptr[g] == rd_ptr[g]);
            assign full_o[g]         = (wr_ptr[g][CW-1] != rd_ptr[g][CW-1]) &&
                                       (wr_ptr[g][CW-2:0] == rd_ptr[g][CW-2:0]);
            assign almost_full_o[g]  = (cnt[g] >= CW'(AF_THRESH));
            assign almost_empty_o[g] = (cnt[g] <= CW'(AE_THRESH));
            assign count_o[g*CW +: CW] = cnt[g];
        end
    endgenerate

    // Select the addressed channel's state; an id beyond NUM_CH looks full
    // and empty so it can never be written or popped.
    always_comb begin
        wr_full_sel  = 1'b1;
        wr_clr_sel   = 1'b0;
        wr_low       = '0;
        rd_empty_sel = 1'b1;
        rd_clr_sel   = 1'b0;
        rd_low       = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (wr_ch_i == CHW'(c)) begin
                wr_full_sel = full_o[c];
                wr_clr_sel  = clear_i[c];
                wr_low      = wr_ptr[c][CW-2:0];
            end
            if (rd_ch_i == CHW'(c)) begin
                rd_empty_sel = empty_o[c];
                rd_clr_sel   = clear_i[c];
                rd_low       = rd_ptr[c][CW-2:0];
            end
        end
    end

    assign wr_ready_o = ~wr_full_sel;
    assign wr_acc     = wr_valid_i & ~wr_full_sel & ~wr_clr_sel;
    assign rd_acc     = rd_req_i & ~rd_empty_sel & ~rd_clr_sel;
    assign waddr      = {wr_ch_i, wr_low};
    assign raddr      = {rd_ch_i, rd_low};

    // Pointer update: clear beats any same-cycle write or read on a channel.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (clear_i[c]) begin
                    wr_ptr[c] <= '0;
                    rd_ptr[c] <= '0;
                end else begin
                    if (wr_acc && (wr_ch_i == CHW'(c)))
                        wr_ptr[c] <= wr_ptr[c] + 1'b1;
                    if (rd_acc && (rd_ch_i == CHW'(c)))
                        rd_ptr[c] <= rd_ptr[c] + 1'b1;
                end
            end
        end
    end

    // Storage write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[waddr] <= wr_data_i;
    end

    // Registered read port: one-cycle latency, data/channel hold when idle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_valid_o <= 1'b0;
            rd_ch_o    <= '0;
            rd_data_o  <= '0;
        end else begin
            rd_valid_o <= rd_acc;
            if (rd_acc) begin
                rd_ch_o   <= rd_ch_i;
                rd_data_o <= mem[raddr];
            end
        end
    end

`ifdef DMA_CHAN_FIFO_ERR_FLAGS_EN
    // Sticky error flags, set by attempts against full/empty channels.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            err_ovf_o <= '0;
            err_udf_o <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (clear_i[c]) begin
                    err_ovf_o[c] <= 1'b0;
                    err_udf_o[c] <= 1'b0;
                end else begin
                    if (wr_valid_i && (wr_ch_i == CHW'(c)) && full_o[c])
                        err_ovf_o[c] <= 1'b1;
                    if (rd_req_i && (rd_ch_i == CHW'(c)) && empty_o[c])
                        err_udf_o[c] <= 1'b1;
                end
            end
        end
    end
`endif

endmodule
